imu_pwm_controller: RTL and testbench
=====================================

Name: imu_pwm_controller

Overview:
Parametrised successor to the single-channel accelerometer-to-PWM block. It takes signed accelerometer samples qualified by the IMU interface's ReadDone strobe and averages them over a power-of-two window. It converts the mean into a saturated duty value with a selectable sign mode. A free-running, prescaled PWM generator then drives the output, with glitch-free duty updates at period boundaries. It sits between the IMU interface and the motor/actuator pin.

Parameters:
DATA_WIDTH, 16, width of signed AccelZ sample
AVG_LOG2, 3, averaging window = 2^AVG_LOG2 samples (1..6)
PWM_WIDTH, 10, PWM resolution; period = 2^PWM_WIDTH ticks
PRESCALE, 4, Clock cycles per PWM tick (>=1)
OFFSET, 256, signed duty offset added to/subtracted from mean

Ports:
Clock  in  1  system clock, all logic rising-edge
Resetn  in  1  asynchronous active-low reset
ReadDone  in  1  IMU read-complete level, synchronous to Clock; falling edge = new sample
AccelZ  in  DATA_WIDTH  signed sample, valid at ReadDone falling edge
Enable  in  1  PWM output enable
Invert  in  1  mode: 0 raw = OFFSET - mean, 1 raw = OFFSET + mean
Duty  out  PWM_WIDTH  last computed (pending) duty
DutyValid  out  1  one-cycle pulse when Duty updates
PeriodStart  out  1  one-cycle pulse at start of each PWM period
PWMsignal  out  1  PWM output

Behaviour:
- Reset (async, Resetn=0): accumulator, sample count, ReadDone history, prescaler, period counter, active duty, Duty, DutyValid, PeriodStart, PWMsignal all 0. Release mid-operation discards all partial sums.
- Sample event: registered ReadDonePrev=1 and ReadDone=0. At most one event per falling edge. No event on the first cycle after reset, because ReadDonePrev resets to 0.
- Accumulator width: DATA_WIDTH+AVG_LOG2, signed. AccelZ is sign-extended.
- ACCUM state: on each event, accum += AccelZ and count++.
- On the event where count = 2^AVG_LOG2-1: sum = accum + AccelZ; mean = sum >>> AVG_LOG2 (arithmetic, rounds toward -inf); mean is registered, accum and count clear to 0, and the state goes to CALC.
- CALC state (1 cycle): raw = OFFSET -/+ mean per Invert, computed in DATA_WIDTH+2 signed bits. Saturate: raw<0 gives 0; raw>2^PWM_WIDTH-1 gives 2^PWM_WIDTH-1.
- CALC output: Duty loads the saturated value and DutyValid=1 for exactly this cycle. Next state is ACCUM.
- Latency: DutyValid is high on the second Clock edge after the cycle in which the final event is detected.
- An event occurring during CALC is accumulated as sample 1 of the next window and is never dropped.
- Invert is sampled in CALC only.
- Prescaler: counts 0..PRESCALE-1 while Enable=1. Tick = prescaler at PRESCALE-1. PRESCALE=1 gives a tick every cycle.
- Period counter: advances on tick and wraps from 2^PWM_WIDTH-1 to 0.
- Active-duty load: on the wrap tick, active duty loads from Duty and PeriodStart pulses for 1 cycle, coincident with the counter becoming 0. A Duty change mid-period never alters the current period.
- PWMsignal = Enable & (period counter < active duty), registered.
- Duty 0 gives PWMsignal constantly 0. Maximum duty gives high for 2^PWM_WIDTH-1 of 2^PWM_WIDTH ticks.
- Enable=0: prescaler and period counter held at 0, PWMsignal=0, no PeriodStart. Averaging and Duty updates continue.
- Enable 0->1: on the first enabled cycle, active duty loads from Duty and PeriodStart pulses.

Test Plan:
1. Defaults, Invert=0: 8 ReadDone falls with AccelZ=64 -> DutyValid one cycle, Duty=192; next period PWMsignal high for 192x4 clocks of 4096.
2. 8 samples of -100 -> Duty=356. Then 8 samples of 64 with Invert=1 -> Duty=320. Seven samples of 0 plus one of -1 -> mean -1, Duty=257.
3. Saturation: 8 samples of 1000 -> Duty=0, PWMsignal never high. 8 samples of -32768 -> Duty=1023, PWMsignal low only during count 1023.
4. New Duty arrives mid-period -> current period keeps the old high time; the new width applies from the next PeriodStart. An event in the CALC cycle is counted toward the next window.
5. Resetn pulsed low after 5 samples of 500 -> all outputs 0; then 8 samples of 64 -> Duty=192.
6. Enable low for 100 cycles -> PWMsignal=0, no PeriodStart. Enable high -> PeriodStart on the first enabled cycle, and the waveform uses the current Duty.

Source files
------------

// File: rtl/imu_pwm_controller.sv
// Accelerometer-to-PWM controller: averages signed AccelZ samples over 2^AVG_LOG2 reads,
// maps the mean to a saturated duty, and drives a prescaled PWM with period-aligned updates.
module imu_pwm_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int AVG_LOG2   = 3,
  parameter int PWM_WIDTH  = 10,
  parameter int PRESCALE   = 4,
  parameter int OFFSET     = 256
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  ReadDone,
  input  logic [DATA_WIDTH-1:0] AccelZ,
  input  logic                  Enable,
  input  logic                  Invert,
  output logic [PWM_WIDTH-1:0]  Duty,
  output logic                  DutyValid,
  output logic                  PeriodStart,
  output logic                  PWMsignal
);

  localparam int ACC_W = DATA_WIDTH + AVG_LOG2;
  localparam int RAW_W = DATA_WIDTH + 2;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [AVG_LOG2-1:0]   COUNT_LAST = '1;
  localparam logic [PWM_WIDTH-1:0]  PWM_MAX    = '1;
  localparam logic [PS_W-1:0]       PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic signed [RAW_W-1:0] OFFSET_EXT = RAW_W'(OFFSET);
  localparam logic signed [RAW_W-1:0] RAW_MAX    = RAW_W'((1 << PWM_WIDTH) - 1);

  typedef enum logic {S_ACCUM, S_CALC} state_t;

  state_t                       state_reg, state_next;
  logic                         readdone_prev_reg;
  logic signed [ACC_W-1:0]      accum_reg, accum_next;
  logic [AVG_LOG2-1:0]          count_reg, count_next;
  logic signed [DATA_WIDTH-1:0] mean_reg, mean_next;
  logic [PWM_WIDTH-1:0]         duty_reg, duty_next;
  logic                         dutyvalid_reg, dutyvalid_next;

  logic                         enable_prev_reg;
  logic [PS_W-1:0]              presc_reg, presc_next;
  logic [PWM_WIDTH-1:0]         cnt_reg, cnt_next;
  logic [PWM_WIDTH-1:0]         active_reg, active_next;
  logic                         periodstart_reg, periodstart_next;
  logic                         pwm_reg, pwm_next;

  logic                         sample_event;
  logic signed [ACC_W-1:0]      accel_ext;
  logic signed [ACC_W-1:0]      sum_full;
  logic signed [RAW_W-1:0]      mean_ext;
  logic signed [RAW_W-1:0]      raw;
  logic [PWM_WIDTH-1:0]         duty_sat;
  logic                         tick;

  assign sample_event = readdone_prev_reg & ~ReadDone;
  assign accel_ext    = ACC_W'($signed(AccelZ));
  assign sum_full     = accum_reg + accel_ext;
  assign mean_ext     = RAW_W'(mean_reg);
  assign raw          = Invert ? (OFFSET_EXT + mean_ext) : (OFFSET_EXT - mean_ext);
  assign tick         = Enable && (presc_reg == PS_LAST);

  always_comb begin
    if (raw[RAW_W-1])
      duty_sat = '0;
    else if (raw > RAW_MAX)
      duty_sat = PWM_MAX;
    else
      duty_sat = raw[PWM_WIDTH-1:0];
  end

  // Averaging datapath runs in both states so an event during CALC starts the next window.
  always_comb begin
    state_next     = state_reg;
    accum_next     = accum_reg;
    count_next     = count_reg;
    mean_next      = mean_reg;
    duty_next      = duty_reg;
    dutyvalid_next = 1'b0;

    case (state_reg)
      S_ACCUM: if (sample_event && count_reg == COUNT_LAST) state_next = S_CALC;
      S_CALC: begin
        state_next     = S_ACCUM;
        duty_next      = duty_sat;
        dutyvalid_next = 1'b1;
      end
      default: state_next = S_ACCUM;
    endcase

    if (sample_event) begin
      if (count_reg == COUNT_LAST) begin
        mean_next  = DATA_WIDTH'(sum_full >>> AVG_LOG2);
        accum_next = '0;
        count_next = '0;
      end else begin
        accum_next = sum_full;
        count_next = count_reg + 1'b1;
      end
    end
  end

  // First enabled cycle restarts the period at count 0 with the current duty.
  always_comb begin
    presc_next       = '0;
    cnt_next         = '0;
    active_next      = active_reg;
    periodstart_next = 1'b0;
    pwm_next         = Enable && (cnt_reg < active_reg);

    if (Enable) begin
      if (!enable_prev_reg) begin
        active_next      = duty_reg;
        periodstart_next = 1'b1;
      end else begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        cnt_next   = tick ? cnt_reg + 1'b1 : cnt_reg;
        if (tick && cnt_reg == PWM_MAX) begin
          active_next      = duty_reg;
          periodstart_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg         <= S_ACCUM;
      readdone_prev_reg <= 1'b0;
      accum_reg         <= '0;
      count_reg         <= '0;
      mean_reg          <= '0;
      duty_reg          <= '0;
      dutyvalid_reg     <= 1'b0;
      enable_prev_reg   <= 1'b0;
      presc_reg         <= '0;
      cnt_reg           <= '0;
      active_reg        <= '0;
      periodstart_reg   <= 1'b0;
      pwm_reg           <= 1'b0;
    end else begin
      state_reg         <= state_next;
      readdone_prev_reg <= ReadDone;
      accum_reg         <= accum_next;
      count_reg         <= count_next;
      mean_reg          <= mean_next;
      duty_reg          <= duty_next;
      dutyvalid_reg     <= dutyvalid_next;
      enable_prev_reg   <= Enable;
      presc_reg         <= presc_next;
      cnt_reg           <= cnt_next;
      active_reg        <= active_next;
      periodstart_reg   <= periodstart_next;
      pwm_reg           <= pwm_next;
    end
  end

  assign Duty        = duty_reg;
  assign DutyValid   = dutyvalid_reg;
  assign PeriodStart = periodstart_reg;
  assign PWMsignal   = pwm_reg;

endmodule

// File: tb/tb_imu_pwm_controller.sv
// Directed bench for imu_pwm_controller with default parameters (period 1024 ticks x 4 clocks).
module tb_imu_pwm_controller;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        ReadDone = 1'b0;
  logic [15:0] AccelZ = '0;
  logic        Enable = 1'b0;
  logic        Invert = 1'b0;
  logic [9:0]  Duty;
  logic        DutyValid;
  logic        PeriodStart;
  logic        PWMsignal;

  int compared = 0;
  int mismatched = 0;
  int dv_q[$];

  imu_pwm_controller dut (
    .Clock(Clock), .Resetn(Resetn), .ReadDone(ReadDone), .AccelZ(AccelZ),
    .Enable(Enable), .Invert(Invert), .Duty(Duty), .DutyValid(DutyValid),
    .PeriodStart(PeriodStart), .PWMsignal(PWMsignal)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (DutyValid === 1'b1) dv_q.push_back(int'(Duty));

  task automatic tick_n(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic send_sample(input int v);
    @(posedge Clock); #1 ReadDone = 1'b1; AccelZ = 16'(v);
    @(posedge Clock); #1 ReadDone = 1'b0;
  endtask

  task automatic run_window(input string name, input int v_main, input int v_last,
                            input logic inv, input int exp_duty);
    Invert = inv;
    repeat (7) send_sample(v_main);
    send_sample(v_last);
    @(posedge Clock); #1;
    compared++;
    if (DutyValid !== 1'b0) begin
      mismatched++; $display("FAIL %s_early_valid: got %0b expected 0", name, DutyValid);
    end
    @(posedge Clock); #1;
    compared++;
    if (DutyValid !== 1'b1) begin
      mismatched++; $display("FAIL %s_valid: got %0b expected 1", name, DutyValid);
    end
    compared++;
    if (Duty !== 10'(exp_duty)) begin
      mismatched++; $display("FAIL %s_duty: got %0d expected %0d", name, Duty, exp_duty);
    end
    @(posedge Clock); #1;
    compared++;
    if (DutyValid !== 1'b0) begin
      mismatched++; $display("FAIL %s_valid_pulse: got %0b expected 0", name, DutyValid);
    end
  endtask

  task automatic wait_period_start(input string name);
    int n = 0;
    do begin @(posedge Clock); #1; n++; end while (PeriodStart !== 1'b1 && n < 5000);
    compared++;
    if (PeriodStart !== 1'b1) begin
      mismatched++; $display("FAIL %s_period_start_timeout: got %0d cycles expected <5000", name, n);
    end
  endtask

  task automatic count_high(input string name, input int exp_high);
    int h = 0;
    repeat (4096) begin @(posedge Clock); #1; if (PWMsignal === 1'b1) h++; end
    compared++;
    if (h != exp_high) begin
      mismatched++; $display("FAIL %s_high_time: got %0d expected %0d", name, h, exp_high);
    end
  endtask

  task automatic test_reset();
    #2 Resetn = 1'b0;
    #1;
    compared++;
    if ({Duty, DutyValid, PeriodStart, PWMsignal} !== 13'd0) begin
      mismatched++; $display("FAIL reset_outputs: got %h expected 0", {Duty, DutyValid, PeriodStart, PWMsignal});
    end
    Enable = 1'b1;
    tick_n(3);
    Resetn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    run_window("mean64", 64, 64, 1'b0, 192);
    wait_period_start("basic");
    count_high("basic", 768);
    $display("test_basic done");
  endtask

  task automatic test_signs();
    run_window("neg100", -100, -100, 1'b0, 356);
    run_window("invert64", 64, 64, 1'b1, 320);
    run_window("floor_m1", 0, -1, 1'b0, 257);
    $display("test_signs done");
  endtask

  task automatic test_saturation();
    run_window("sat_low", 1000, 1000, 1'b0, 0);
    wait_period_start("sat_low");
    count_high("sat_low", 0);
    run_window("sat_high", -32768, -32768, 1'b0, 1023);
    wait_period_start("sat_high");
    count_high("sat_high", 4092);
    $display("test_saturation done");
  endtask

  task automatic test_mid_period();
    run_window("mid_setup", 64, 64, 1'b0, 192);
    wait_period_start("mid");
    fork
      count_high("mid_old_width", 768);
      run_window("mid_update", -100, -100, 1'b0, 356);
    join
    count_high("mid_new_width", 1424);
    $display("test_mid_period done");
  endtask

  task automatic test_back_to_back();
    dv_q.delete();
    Invert = 1'b0;
    repeat (8) send_sample(64);
    repeat (8) send_sample(-100);
    tick_n(5);
    compared++;
    if (dv_q.size() != 2) begin
      mismatched++; $display("FAIL b2b_count: got %0d expected 2", dv_q.size());
    end else begin
      compared++;
      if (dv_q[0] != 192) begin
        mismatched++; $display("FAIL b2b_first: got %0d expected 192", dv_q[0]);
      end
      compared++;
      if (dv_q[1] != 356) begin
        mismatched++; $display("FAIL b2b_second: got %0d expected 356", dv_q[1]);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    Invert = 1'b0;
    repeat (5) send_sample(500);
    @(posedge Clock); #2 Resetn = 1'b0;
    #1;
    compared++;
    if ({Duty, DutyValid, PeriodStart, PWMsignal} !== 13'd0) begin
      mismatched++; $display("FAIL reset_mid_outputs: got %h expected 0", {Duty, DutyValid, PeriodStart, PWMsignal});
    end
    tick_n(2);
    Resetn = 1'b1;
    run_window("after_reset", 64, 64, 1'b0, 192);
    $display("test_reset_mid done");
  endtask

  task automatic test_enable();
    int pwm_hi = 0;
    int ps_hi = 0;
    @(posedge Clock); #1 Enable = 1'b0;
    run_window("disabled_avg", -100, -100, 1'b0, 356);
    repeat (100) begin
      @(posedge Clock); #1;
      if (PWMsignal === 1'b1) pwm_hi++;
      if (PeriodStart === 1'b1) ps_hi++;
    end
    compared++;
    if (pwm_hi != 0) begin
      mismatched++; $display("FAIL disabled_pwm: got %0d high cycles expected 0", pwm_hi);
    end
    compared++;
    if (ps_hi != 0) begin
      mismatched++; $display("FAIL disabled_period_start: got %0d pulses expected 0", ps_hi);
    end
    Enable = 1'b1;
    @(posedge Clock); #1;
    compared++;
    if (PeriodStart !== 1'b1) begin
      mismatched++; $display("FAIL enable_period_start: got %0b expected 1", PeriodStart);
    end
    count_high("enable_width", 1424);
    $display("test_enable done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_saturation();
    test_mid_period();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
